// File: rtl/ins_mem_responder.sv
// Instruction-memory responder: accepts one fetch at a time, answers after LATENCY edges,
// and exposes a free-running program-load write port into the backing array.
module ins_mem_responder #(
  parameter int DWIDTH  = 16,
  parameter int AWIDTH  = 8,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_ram_in,
  input  logic [DWIDTH-1:0] addr,
  output logic [DWIDTH-1:0] ins,
  output logic              en_ram_out,
  output logic              busy,
  input  logic              load_en,
  input  logic [AWIDTH-1:0] load_addr,
  input  logic [DWIDTH-1:0] load_data,
  output logic              oob_err
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] ins_d;
  logic              out_d, busy_d, oob_d;
  logic [DWIDTH-1:0] rd_word;
  logic              oob_hit;

  logic [DWIDTH-1:0] mem [2**AWIDTH];

  // Array is deliberately outside reset so a loaded program survives rst_n.
  always_ff @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
  end

  // Combinational read of the current array; the write above lands via NBA,
  // so a same-edge write to the fetched word yields the old contents.
  assign rd_word = mem[addr_q[AWIDTH-1:0]];
  assign oob_hit = |(addr_q >> AWIDTH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      ins        <= '0;
      en_ram_out <= 1'b0;
      busy       <= 1'b0;
      oob_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      ins        <= ins_d;
      en_ram_out <= out_d;
      busy       <= busy_d;
      oob_err    <= oob_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    ins_d   = ins;
    out_d   = 1'b0;
    busy_d  = busy;
    oob_d   = oob_err;
    case (state_q)
      IDLE: begin
        if (en_ram_in) begin
          addr_d  = addr;
          cnt_d   = CW'(LATENCY - 1);
          busy_d  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          out_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
          if (oob_hit) begin
            ins_d = '0;
            oob_d = 1'b1;
          end else begin
            ins_d = rd_word;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/ins_mem_responder.md
Name: ins_mem_responder

Overview:
Instruction-memory responder for the CPU fetch interface. The CPU drives addr and en_ram_in; this block returns ins with a one-cycle en_ram_out pulse after a fixed latency. It holds a 2^AWIDTH x DWIDTH program array, which a separate load port writes: a loader/bench before run, or any time after that.

Parameters:
DWIDTH, 16, instruction/data width; matches CPU ins and addr width
AWIDTH, 8, index width; array depth = 2^AWIDTH words
LATENCY, 2, rising edges from request acceptance to response; legal range >= 1

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
en_ram_in  input  1  fetch request from CPU
addr  input  DWIDTH  fetch word address from CPU (PC)
ins  output  DWIDTH  fetched instruction, registered
en_ram_out  output  1  one-cycle pulse: ins valid for the accepted request
busy  output  1  request outstanding; new requests ignored
load_en  input  1  program-load write strobe
load_addr  input  AWIDTH  program-load word address
load_data  input  DWIDTH  program-load word
oob_err  output  1  sticky: a fetch hit an address >= 2^AWIDTH

Behaviour:
- Reset (rst_n=0 at rising edge): state=IDLE, ins=0, en_ram_out=0, busy=0, oob_err=0, counter=0. Array contents are not reset.
- Reset mid-WAIT aborts the pending fetch. No en_ram_out is produced for that fetch.
- State machine has two states, IDLE and WAIT.
- IDLE, en_ram_in=1 at edge E0:
  - latch addr into addr_q
  - counter=LATENCY-1
  - busy=1, go to WAIT
- IDLE, en_ram_in=0: stay in IDLE. en_ram_out=0.
- WAIT, counter!=0: decrement the counter. en_ram_in is ignored, not queued.
- WAIT, counter==0 (this is edge E_LATENCY):
  - ins <= mem[addr_q[AWIDTH-1:0]], or 0 if out of range
  - en_ram_out <= 1, busy <= 0, go to IDLE
- en_ram_out is high for exactly one cycle; it deasserts at the next edge.
- ins holds its value until the next response or reset.
- Timing: busy is high from E0 through E_LATENCY. A request held during the en_ram_out cycle is accepted at E_LATENCY+1.
- Throughput: with en_ram_in held high, one fetch per LATENCY+1 cycles.
- Out of range: if addr_q[DWIDTH-1:AWIDTH] != 0, the response still occurs on schedule with ins=0, and oob_err is set to 1. oob_err stays 1 until reset.
- Load port:
  - on any edge with load_en=1, mem[load_addr] <= load_data, in any state
  - the load port never stalls and never affects busy
- Read/write collision: if a response edge reads the address being written at the same edge, ins gets the old contents (read-before-write). Writes at earlier edges are visible.
- The counter is sized to hold LATENCY-1 (at least 1 bit). With LATENCY=1, the response comes at the edge right after acceptance.
- No combinational path from any input to any output.

Test Plan:
- Reset, load mem[0]=16'h1234 and mem[1]=16'hABCD, then pulse en_ram_in with addr=0 at E0 (LATENCY=2):
  - busy=1 from E0 to E2
  - en_ram_out=1 only in the cycle after E2, with ins=16'h1234
- Hold en_ram_in high with addr=0, then addr=1 after the first response:
  - en_ram_out pulses exactly 3 cycles apart
  - ins=16'h1234, then 16'hABCD
- Pulse en_ram_in with addr=1 while busy (between E0 and E2):
  - only the original request's single response appears
  - no extra en_ram_out
- load_en to mem[0]=16'h5555 on the response edge of a fetch of addr 0:
  - that response returns 16'h1234
  - the next fetch of addr 0 returns 16'h5555
- Fetch addr=16'h0100 (AWIDTH=8):
  - response on schedule with ins=16'h0000
  - oob_err=1 and stays set through later valid fetches until rst_n=0
- Assert rst_n=0 one cycle after acceptance:
  - no en_ram_out is ever produced
  - busy=0, ins=0
  - array contents are intact; refetching addr 1 returns 16'hABCD
